// File: rtl/mem_access.sv
// M-stage data memory access: issues one bus request per load/store instruction,
// stalls the pipeline until the response arrives, and aligns/extends load data.
module mem_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_read_m,
  input  logic        mem_write_m,
  input  logic [1:0]  size_m,
  input  logic        unsigned_m,
  input  logic [31:0] addr_m,
  input  logic [31:0] wdata_m,
  input  logic        advance_m,
  output logic        dreq_valid,
  output logic [31:0] dreq_addr,
  output logic [3:0]  dreq_strobe,
  output logic [31:0] dreq_data,
  input  logic        dresp_ok,
  input  logic [31:0] dresp_data,
  output logic        mem_busy,
  output logic [31:0] rdata_m,
  output logic        addr_err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_data_q, req_data_d;
  logic [3:0]  req_strobe_q, req_strobe_d;

  logic        want;
  logic        is_load;
  logic        size_bad;
  logic        access;
  logic        issue;
  logic        waiting;
  logic        resp;
  logic        show_load;
  logic [3:0]  st_strobe;
  logic [31:0] st_data;
  logic [31:0] raw;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext;

  // A store wins when both load and store are flagged.
  assign want    = mem_read_m | mem_write_m;
  assign is_load = mem_read_m & ~mem_write_m;

  always_comb begin
    size_bad = 1'b0;
    case (size_m)
      2'b00:   size_bad = 1'b0;
      2'b01:   size_bad = addr_m[0];
      2'b10:   size_bad = (addr_m[1:0] != 2'b00);
      default: size_bad = 1'b1;
    endcase
  end

  assign access = want & ~size_bad;

  always_comb begin
    st_strobe = 4'b0000;
    st_data   = wdata_m;
    if (mem_write_m) begin
      case (size_m)
        2'b00: begin
          st_strobe = 4'b0001 << addr_m[1:0];
          st_data   = {4{wdata_m[7:0]}};
        end
        2'b01: begin
          st_strobe = 4'b0011 << addr_m[1:0];
          st_data   = {2{wdata_m[15:0]}};
        end
        default: begin
          st_strobe = 4'b1111;
          st_data   = wdata_m;
        end
      endcase
    end
  end

  // While waiting, the bus sees the registered copy so the request stays stable.
  assign issue       = resetn & (state_q == IDLE) & access;
  assign waiting     = resetn & (state_q == WAIT);
  assign dreq_valid  = issue | waiting;
  assign dreq_addr   = waiting ? req_addr_q   : addr_m;
  assign dreq_strobe = waiting ? req_strobe_q : st_strobe;
  assign dreq_data   = waiting ? req_data_q   : st_data;
  assign resp        = dreq_valid & dresp_ok;
  assign mem_busy    = dreq_valid & ~dresp_ok;
  assign addr_err    = resetn & want & size_bad;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    req_strobe_d = req_strobe_q;
    case (state_q)
      IDLE: begin
        if (access) begin
          req_addr_d   = addr_m;
          req_data_d   = st_data;
          req_strobe_d = st_strobe;
          if (dresp_ok) state_d = advance_m ? IDLE : DONE;
          else          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dresp_ok) state_d = advance_m ? IDLE : DONE;
      end
      DONE: begin
        if (advance_m) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (resp) hold_d = dresp_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      req_strobe_q <= '0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      req_strobe_q <= req_strobe_d;
    end
  end

  // Load result: live bus data in the response cycle, held copy afterwards.
  assign raw       = resp ? dresp_data : hold_q;
  assign show_load = resetn & is_load & (resp | (state_q == DONE));

  always_comb begin
    sel_byte = raw[7:0];
    case (addr_m[1:0])
      2'b00:   sel_byte = raw[7:0];
      2'b01:   sel_byte = raw[15:8];
      2'b10:   sel_byte = raw[23:16];
      default: sel_byte = raw[31:24];
    endcase
    sel_half = addr_m[1] ? raw[31:16] : raw[15:0];
    case (size_m)
      2'b00:   ext = unsigned_m ? {24'b0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      2'b01:   ext = unsigned_m ? {16'b0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: ext = raw;
    endcase
  end

  assign rdata_m = show_load ? ext : '0;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus queues expected bus requests/results,
// a negedge monitor compares them whenever the DUT drives a request.
module tb_mem_access;

  logic        clk;
  logic        resetn;
  logic        mem_read_m;
  logic        mem_write_m;
  logic [1:0]  size_m;
  logic        unsigned_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic        advance_m;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_ok;
  logic [31:0] dresp_data;
  logic        mem_busy;
  logic [31:0] rdata_m;
  logic        addr_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic        is_load;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t pending;
  bit   pending_valid = 0;

  mem_access dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem_read_m  (mem_read_m),
    .mem_write_m (mem_write_m),
    .size_m      (size_m),
    .unsigned_m  (unsigned_m),
    .addr_m      (addr_m),
    .wdata_m     (wdata_m),
    .advance_m   (advance_m),
    .dreq_valid  (dreq_valid),
    .dreq_addr   (dreq_addr),
    .dreq_strobe (dreq_strobe),
    .dreq_data   (dreq_data),
    .dresp_ok    (dresp_ok),
    .dresp_data  (dresp_data),
    .mem_busy    (mem_busy),
    .rdata_m     (rdata_m),
    .addr_err    (addr_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expectAccess(input logic [31:0] addr, input logic [3:0] strobe,
                              input logic [31:0] data, input logic is_load, input logic [31:0] rdata);
    pending.addr    = addr;
    pending.strobe  = strobe;
    pending.data    = data;
    pending.is_load = is_load;
    pending.rdata   = rdata;
    pending_valid   = 1;
  endtask

  // One pipeline cycle: drive just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic rst, input logic rd, input logic wr, input logic [1:0] sz,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                               input logic adv, input logic ok, input logic [31:0] bus);
    @(posedge clk);
    #1;
    resetn      = rst;
    mem_read_m  = rd;
    mem_write_m = wr;
    size_m      = sz;
    unsigned_m  = uns;
    addr_m      = addr;
    wdata_m     = wd;
    advance_m   = adv;
    dresp_ok    = ok;
    dresp_data  = bus;
    if (pending_valid) begin
      exp_q.push_back(pending);
      pending_valid = 0;
    end
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1, 0, 0, 2'b00, 0, 32'h0, 32'h0, 1, 0, 32'h0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn === 1'b1 && dreq_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_req: got dreq_valid=1 addr 0x%08h expected no request at %0t",
                 dreq_addr, $time);
      end else begin
        e = exp_q[0];
        checkOutput("req_addr", dreq_addr, e.addr);
        checkOutput("req_strobe", {28'b0, dreq_strobe}, {28'b0, e.strobe});
        if (!e.is_load) checkOutput("req_data", dreq_data, e.data);
        if (dresp_ok === 1'b1) begin
          if (e.is_load) checkOutput("rdata_resp", rdata_m, e.rdata);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    resetn      = 0;
    mem_read_m  = 0;
    mem_write_m = 0;
    size_m      = 2'b00;
    unsigned_m  = 0;
    addr_m      = 32'h0;
    wdata_m     = 32'h0;
    advance_m   = 0;
    dresp_ok    = 0;
    dresp_data  = 32'h0;

    // Reset with an illegal load and a stray response on the bus
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h0000_0002, 32'h0, 0, 1, 32'h1234_5678);
    checkOutput("rst_valid", {31'b0, dreq_valid}, 32'h0);
    checkOutput("rst_busy", {31'b0, mem_busy}, 32'h0);
    checkOutput("rst_rdata", rdata_m, 32'h0);
    checkOutput("rst_addr_err", {31'b0, addr_err}, 32'h0);
    applyStimulus(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 0, 0, 32'h0);
    idleCycle();
    checkOutput("idle_valid", {31'b0, dreq_valid}, 32'h0);

    // LW with three stall cycles then a response
    expectAccess(32'h8000_0004, 4'b0000, 32'h0, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 2'b10, 0, 32'h8000_0004, 32'h0, 0, 0, 32'h0);
      checkOutput("lw_busy", {31'b0, mem_busy}, 32'h1);
    end
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h8000_0004, 32'h0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("lw_busy_resp", {31'b0, mem_busy}, 32'h0);
    // Held in M afterwards: no reissue, result from the hold register
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, 0, 2'b10, 0, 32'h8000_0004, 32'h0, 0, 0, 32'h0);
      checkOutput("done_valid", {31'b0, dreq_valid}, 32'h0);
      checkOutput("done_busy", {31'b0, mem_busy}, 32'h0);
      checkOutput("done_rdata", rdata_m, 32'hDEAD_BEEF);
    end
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h8000_0004, 32'h0, 1, 0, 32'h0);
    checkOutput("done_adv_valid", {31'b0, dreq_valid}, 32'h0);

    // LB / LBU of the top byte, response in the issue cycle
    expectAccess(32'h1000_0003, 4'b0000, 32'h0, 1, 32'hFFFF_FF80);
    applyStimulus(1, 1, 0, 2'b00, 0, 32'h1000_0003, 32'h0, 1, 1, 32'h80FF_0000);
    checkOutput("lb_busy", {31'b0, mem_busy}, 32'h0);
    expectAccess(32'h1000_0003, 4'b0000, 32'h0, 1, 32'h0000_0080);
    applyStimulus(1, 1, 0, 2'b00, 1, 32'h1000_0003, 32'h0, 1, 1, 32'h80FF_0000);

    // LH of the upper half, one wait cycle, then read back from DONE
    expectAccess(32'h1000_0002, 4'b0000, 32'h0, 1, 32'hFFFF_8001);
    applyStimulus(1, 1, 0, 2'b01, 0, 32'h1000_0002, 32'h0, 0, 0, 32'h0);
    checkOutput("lh_addr_err", {31'b0, addr_err}, 32'h0);
    checkOutput("lh_busy", {31'b0, mem_busy}, 32'h1);
    applyStimulus(1, 1, 0, 2'b01, 0, 32'h1000_0002, 32'h0, 0, 1, 32'h8001_7FFF);
    applyStimulus(1, 1, 0, 2'b01, 0, 32'h1000_0002, 32'h0, 0, 0, 32'h0000_0000);
    checkOutput("lh_hold_rdata", rdata_m, 32'hFFFF_8001);
    applyStimulus(1, 1, 0, 2'b01, 0, 32'h1000_0002, 32'h0, 1, 0, 32'h0);

    // SH to the upper half, same-cycle response
    expectAccess(32'h2000_0002, 4'b1100, 32'h1234_1234, 0, 32'h0);
    applyStimulus(1, 0, 1, 2'b01, 0, 32'h2000_0002, 32'h0000_1234, 1, 1, 32'h0);
    checkOutput("sh_busy", {31'b0, mem_busy}, 32'h0);

    // SB to lane 1 with one wait cycle
    expectAccess(32'h3000_0001, 4'b0010, 32'hABAB_ABAB, 0, 32'h0);
    applyStimulus(1, 0, 1, 2'b00, 0, 32'h3000_0001, 32'h0000_00AB, 0, 0, 32'h0);
    checkOutput("sb_busy", {31'b0, mem_busy}, 32'h1);
    applyStimulus(1, 0, 1, 2'b00, 0, 32'h3000_0001, 32'h0000_00AB, 1, 1, 32'h0);
    checkOutput("sb_busy_resp", {31'b0, mem_busy}, 32'h0);

    // Load and store both flagged behaves as SW
    expectAccess(32'h3000_0008, 4'b1111, 32'hCAFE_F00D, 0, 32'h0);
    applyStimulus(1, 1, 1, 2'b10, 0, 32'h3000_0008, 32'hCAFE_F00D, 1, 1, 32'h0);

    // Misaligned and illegal-size accesses
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h4000_0002, 32'h0, 1, 0, 32'h0);
    checkOutput("lw_mis_err", {31'b0, addr_err}, 32'h1);
    checkOutput("lw_mis_valid", {31'b0, dreq_valid}, 32'h0);
    checkOutput("lw_mis_busy", {31'b0, mem_busy}, 32'h0);
    applyStimulus(1, 1, 0, 2'b11, 0, 32'h4000_0000, 32'h0, 1, 0, 32'h0);
    checkOutput("size11_err", {31'b0, addr_err}, 32'h1);
    checkOutput("size11_valid", {31'b0, dreq_valid}, 32'h0);
    applyStimulus(1, 0, 1, 2'b01, 0, 32'h4000_0001, 32'h5555, 1, 0, 32'h0);
    checkOutput("sh_mis_err", {31'b0, addr_err}, 32'h1);
    checkOutput("sh_mis_valid", {31'b0, dreq_valid}, 32'h0);

    // Reset while waiting; the response in the reset cycle is dropped
    expectAccess(32'h5000_0010, 4'b0000, 32'h0, 1, 32'h0);
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h5000_0010, 32'h0, 0, 0, 32'h0);
    applyStimulus(1, 1, 0, 2'b10, 0, 32'h5000_0010, 32'h0, 0, 0, 32'h0);
    checkOutput("wait_busy", {31'b0, mem_busy}, 32'h1);
    applyStimulus(0, 1, 0, 2'b10, 0, 32'h5000_0010, 32'h0, 0, 1, 32'h5555_5555);
    checkOutput("rstw_valid", {31'b0, dreq_valid}, 32'h0);
    checkOutput("rstw_busy", {31'b0, mem_busy}, 32'h0);
    checkOutput("rstw_rdata", rdata_m, 32'h0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    applyStimulus(1, 0, 0, 2'b10, 0, 32'h5000_0010, 32'h0, 1, 0, 32'h0);
    checkOutput("post_rst_valid", {31'b0, dreq_valid}, 32'h0);
    checkOutput("post_rst_busy", {31'b0, mem_busy}, 32'h0);
    checkOutput("post_rst_rdata", rdata_m, 32'h0);

    idleCycle();
    idleCycle();
    checkOutput("queue_empty", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset; synchronous, active-low; clock clk.
REQ-003 mem_read_m  in  1  M-stage instruction is a load.
REQ-004 mem_write_m  in  1  M-stage instruction is a store.
REQ-005 size_m  in  2  access size: 00 byte, 01 half, 10 word; 11 illegal.
REQ-006 unsigned_m  in  1  load zero-extends when 1, sign-extends when 0.
REQ-007 addr_m  in  32  effective address (ALU result of M stage).
REQ-008 wdata_m  in  32  store data, right-aligned.
REQ-009 advance_m  in  1  M pipeline register loads a new instruction at this edge (not StallM).
REQ-010 dreq_valid  out  1  data bus request valid.
REQ-011 dreq_addr  out  32  request address, low 2 bits as addr_m.
REQ-012 dreq_strobe  out  4  byte write enables; 0000 for loads.
REQ-013 dreq_data  out  32  store data shifted to byte lane.
REQ-014 dresp_ok  in  1  bus response; one-cycle pulse, completes the request.
REQ-015 dresp_data  in  32  read data, valid with dresp_ok.
REQ-016 mem_busy  out  1  hazard-unit stall request for M and earlier stages.
REQ-017 rdata_m  out  32  extended load result for the W pipeline register.
REQ-018 addr_err  out  1  misaligned or illegal-size access in M.

Function
REQ-019 The FSM SHALL have states IDLE, WAIT, DONE.
REQ-020 IDLE: an access exists when (mem_read_m or mem_write_m) and addr_err=0.
REQ-021 IDLE with access: dreq_valid=1 combinationally; if dresp_ok the same cycle -> DONE, else -> WAIT.
REQ-022 WAIT: dreq_valid=1 with unchanged addr/strobe/data; dresp_ok -> DONE.
REQ-023 DONE: dreq_valid=0; the request SHALL NOT be reissued while the same instruction is held.
REQ-024 From DONE or IDLE, advance_m=1 SHALL return the FSM to IDLE for the next instruction.
REQ-025 mem_busy SHALL be 1 when there is an access in IDLE or the FSM is in WAIT, and dresp_ok=0 that cycle; otherwise 0.
REQ-026 On dresp_ok, the block SHALL capture dresp_data into a 32-bit hold register.
REQ-027 rdata_m SHALL come from dresp_data in the dresp_ok cycle and from the hold register in DONE.
REQ-028 Load extension: the byte/half SHALL be selected by addr_m[1:0] (little-endian), then sign- or zero-extended to 32 bits; word passes unchanged.
REQ-029 Store strobes: byte 0001<<addr[1:0]; half 0011<<addr[1:0]; word 1111.
REQ-030 Store data: byte replicated to all 4 lanes; half replicated to both halves; word unchanged.
REQ-031 addr_err=1 when: half with addr[0]=1; word with addr[1:0]!=00; or size 11. An erroneous access SHALL issue no request and SHALL NOT assert mem_busy.
REQ-032 Load and store both asserted SHALL be treated as a store.
REQ-033 A mid-transaction drop of mem_read_m/mem_write_m cannot occur; advance_m=1 in WAIT is a protocol violation, and the block SHALL still complete the outstanding response before accepting a new one.

Reset
REQ-034 resetn=0 at an edge SHALL force IDLE and clear the hold register to 0.
REQ-035 During and after reset: dreq_valid=0, mem_busy=0, rdata_m=0, addr_err=0 until a valid access is presented.
REQ-036 A response arriving in the reset cycle SHALL be discarded.

Verification
REQ-037 LW addr 0x80000004, dresp_ok after 3 cycles with 0xDEADBEEF -> mem_busy=1 for 3 cycles, one request held stable, rdata_m=0xDEADBEEF.
REQ-038 LB addr 0x...03, data 0x80FF0000, unsigned=0 -> rdata_m=0xFFFFFF80; with LBU -> 0x00000080.
REQ-039 SH addr 0x...02, wdata 0x00001234 -> strobe 1100, dreq_data 0x12341234; dresp_ok same cycle -> mem_busy=0 throughout.
REQ-040 LW completes, advance_m held 0 for 2 cycles -> no second dreq_valid; rdata_m stays the captured value.
REQ-041 LW addr 0x...02 -> addr_err=1, dreq_valid=0, mem_busy=0.
REQ-042 resetn=0 during WAIT -> next cycle IDLE, dreq_valid=0, rdata_m=0.
